// File: rtl/sine_phase_gen_pkg.sv
// Shared constants for sine_phase_gen: quarter-wave sine table, reset duty value
// and the freq_adj-to-phase-step encoding.
package sine_phase_gen_pkg;

  localparam logic [7:0] DUTY_RESET = 8'd127;
  localparam logic [7:0] DUTY_PEAK  = 8'd254;

  // round(127 + 127*sin(2*pi*k/256)) for k = 0..63; k = 64 is DUTY_PEAK
  localparam logic [7:0] QUARTER_LUT [64] = '{
    8'd127, 8'd130, 8'd133, 8'd136, 8'd139, 8'd143, 8'd146, 8'd149,
    8'd152, 8'd155, 8'd158, 8'd161, 8'd164, 8'd167, 8'd170, 8'd173,
    8'd176, 8'd178, 8'd181, 8'd184, 8'd187, 8'd190, 8'd192, 8'd195,
    8'd198, 8'd200, 8'd203, 8'd205, 8'd208, 8'd210, 8'd212, 8'd215,
    8'd217, 8'd219, 8'd221, 8'd223, 8'd225, 8'd227, 8'd229, 8'd231,
    8'd233, 8'd234, 8'd236, 8'd238, 8'd239, 8'd240, 8'd242, 8'd243,
    8'd244, 8'd245, 8'd247, 8'd248, 8'd249, 8'd249, 8'd250, 8'd251,
    8'd252, 8'd252, 8'd253, 8'd253, 8'd253, 8'd254, 8'd254, 8'd254
  };

  // Bit position of the single set bit in the phase step.
  function automatic int step_lsb(input int phase_w, input logic [1:0] freq_adj);
    return phase_w - 8 + int'(freq_adj);
  endfunction

endpackage

// File: rtl/sine_phase_gen_quarter_lut.sv
// Full-period sine lookup built from the quarter-wave table using mirror
// (address bit 6) and negate (address bit 7).
module sine_quarter_lut
  import sine_phase_gen_pkg::*;
(
  input  logic [7:0] addr,
  output logic [7:0] value
);

  logic [6:0] k;
  logic [7:0] mag;

  always_comb begin
    k     = addr[6] ? (7'd64 - {1'b0, addr[5:0]}) : {1'b0, addr[5:0]};
    mag   = k[6] ? DUTY_PEAK : QUARTER_LUT[k[5:0]];
    value = addr[7] ? (DUTY_PEAK - mag) : mag;
  end

endmodule

// File: rtl/sine_phase_gen.sv
// Frame-paced sine sample generator feeding a PWM over a valid/ready handshake.
// Define SINE_PHASE_GLITCHLESS_EN to change frequency only at phase wrap-around.
module sine_phase_gen
  import sine_phase_gen_pkg::*;
#(
  parameter int PHASE_W = 16,
  parameter int FRAME_W = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [1:0] freq_adj,
  output logic [7:0] duty_cycle,
  output logic       duty_valid,
  input  logic       duty_ready,
  output logic       frame_start,
  output logic       overrun
);

  function automatic logic [PHASE_W-1:0] step_of(input logic [1:0] sel);
    return {{(PHASE_W-1){1'b0}}, 1'b1} << step_lsb(PHASE_W, sel);
  endfunction

  logic [FRAME_W-1:0] frame_cnt;
  logic               wrap;
  logic               vld_p0;
  logic               vld_p1;
  logic [PHASE_W-1:0] phase_p1;
  logic [PHASE_W-1:0] phase_next;
  logic [1:0]         step_sel;
  logic [7:0]         lut_val;

  assign wrap        = en && (frame_cnt == '1);
  assign frame_start = vld_p0;

`ifdef SINE_PHASE_GLITCHLESS_EN
  logic phase_carry;
  assign {phase_carry, phase_next} = {1'b0, phase_p1} + {1'b0, step_of(step_sel)};
`else
  assign phase_next = phase_p1 + step_of(step_sel);
`endif

  // Stage 0: frame counter; vld_p0 marks the clock after a wrap
  always_ff @(posedge clk) begin
    if (rst) begin
      frame_cnt <= '0;
      vld_p0    <= 1'b0;
    end else begin
      vld_p0 <= wrap;
      if (en) frame_cnt <= frame_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      step_sel <= 2'd0;
`ifdef SINE_PHASE_GLITCHLESS_EN
    end else if (vld_p0 && phase_carry) begin
`else
    end else if (wrap) begin
`endif
      step_sel <= freq_adj;
    end
  end

  // Stage 1: phase accumulator advances once per frame
  always_ff @(posedge clk) begin
    if (rst) begin
      phase_p1 <= '0;
      vld_p1   <= 1'b0;
    end else begin
      vld_p1 <= vld_p0;
      if (vld_p0) phase_p1 <= phase_next;
    end
  end

  sine_quarter_lut u_lut (
    .addr  (phase_p1[PHASE_W-1 -: 8]),
    .value (lut_val)
  );

  // Stage 2: registered lookup; a fresh sample always wins over a stale one
  always_ff @(posedge clk) begin
    if (rst) begin
      duty_cycle <= DUTY_RESET;
      duty_valid <= 1'b0;
      overrun    <= 1'b0;
    end else if (vld_p1) begin
      duty_cycle <= lut_val;
      duty_valid <= 1'b1;
      if (duty_valid && !duty_ready) overrun <= 1'b1;
    end else if (duty_ready) begin
      duty_valid <= 1'b0;
    end
  end

endmodule

// File: doc/sine_phase_gen.md
SINE_PHASE_GEN -- requirements
Module: sine_phase_gen

Interface
REQ-001 Parameter: PHASE_W, 16, phase accumulator width; top 8 bits address the sine table.
REQ-002 Parameter: FRAME_W, 8, PWM frame counter width; one sample per 2^FRAME_W clocks.
REQ-003 Port: clk  in  1  sole clock, rising edge.
REQ-004 Port: rst  in  1  reset, synchronous, active-high.
REQ-005 Port: en  in  1  run enable; low freezes frame counter and phase.
REQ-006 Port: freq_adj  in  2  frequency select; phase step = 2^(PHASE_W-8+freq_adj).
REQ-007 Port: duty_cycle  out  8  sine sample for the downstream PWM.
REQ-008 Port: duty_valid  out  1  duty_cycle holds an unconsumed sample.
REQ-009 Port: duty_ready  in  1  downstream accepts sample when high with duty_valid.
REQ-010 Port: frame_start  out  1  one-clock pulse when frame counter wraps to 0.
REQ-011 Port: overrun  out  1  sticky; a sample was overwritten unaccepted.

Function
REQ-012 Frame counter increments by 1 each clk while en=1; wraps 2^FRAME_W-1 -> 0; frame_start pulses on the clk after the wrap.
REQ-013 On each wrap, phase accumulator adds step modulo 2^PHASE_W (steps 256/512/1024/2048 for freq_adj 0..3 at default).
REQ-014 Table address = phase[PHASE_W-1 -: 8]; value(i) = round(127 + 127*sin(2*pi*i/256)); value(0)=127, value(64)=254, value(128)=127, value(192)=0.
REQ-015 Table implemented as 64-entry quarter wave (indices 0..64 via 0..63 plus fixed 254) with mirror (address bit 6) and negate (254-x, address bit 7).
REQ-016 Pipeline: wrap clk -> phase register (cycle 1) -> registered table lookup (cycle 2); duty_valid rises 2 clks after wrap.
REQ-017 Handshake: duty_valid & duty_ready on a clk clears duty_valid next clk unless a new sample loads on that same clk, in which case duty_valid stays 1 with new data.
REQ-018 duty_cycle is stable while duty_valid=1 and duty_ready=0, except REQ-019.
REQ-019 New sample while duty_valid=1 and duty_ready=0: new value overwrites duty_cycle, duty_valid stays 1, overrun sets and holds until rst.
REQ-020 en falling mid-pipeline: in-flight sample completes and is presented; no further wraps until en=1; counter resumes from held value.
REQ-021 freq_adj change takes effect per REQ-027; never alters a sample already in the pipeline.

Reset
REQ-022 rst=1 at clk edge: frame counter 0, phase 0, pipeline empty.
REQ-023 Output reset values: duty_cycle=127, duty_valid=0, frame_start=0, overrun=0.
REQ-024 Step register resets to freq_adj=0 step regardless of freq_adj input.
REQ-025 rst overrides en, duty_ready, and any in-flight sample; rst mid-frame discards pipeline.

Configuration
REQ-026 Macro SINE_PHASE_GLITCHLESS_EN selects frequency-update policy.
REQ-027 Defined: freq_adj is latched into the step register only on a wrap where phase crosses from top half back to zero (carry out of accumulator), so a full period completes at old frequency; undefined: step register loads freq_adj on every frame wrap.

Structure
REQ-028 Shared package holds quarter-wave table constant (64 x 8 bit), reset duty value 127, and freq_adj-to-step encoding.
REQ-029 Sub-module sine_quarter_lut: combinational 8-bit address to 8-bit value per REQ-014/015; registered in parent.

Verification
REQ-030 rst, en=1, freq_adj=0, duty_ready=1: first duty_valid at clk 258 after rst release, duty_cycle=130; sequence tracks value(i) for i=1,2,...; value(64)=254 after 64 frames.
REQ-031 freq_adj=3, duty_ready=1: table index advances by 8 per frame; samples 127,149,...,254 at index 64 after 8 frames; period 32 frames.
REQ-032 duty_ready=0 for 3 frames: duty_valid held, duty_cycle overwritten each frame, overrun=1 after second sample, stays 1 until rst.
REQ-033 en=0 for 1000 clks mid-frame at count 100: no frame_start, phase unchanged; en=1 resumes count at 100.
REQ-034 freq_adj 0->2 at index 10, macro defined: index step stays 1 until index wraps to 0, then 4; macro undefined: step becomes 4 at next frame wrap.
REQ-035 rst asserted 1 clk after frame wrap: no duty_valid pulse, duty_cycle=127, phase 0.
